// File: rtl/ktsnc_div_pkg.sv
// Shared definitions for the KTSNC sequential dividers: FSM encoding,
// counter sizing helper and the quotient reported on divide-by-zero.
package ktsnc_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // Every quotient bit is set on divide-by-zero; replicate to the quotient width.
  localparam logic DBZ_QUOTIENT = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// Handshake and result bundle between a divider client (master) and div_seq (slave).
interface div_seq_if #(
  parameter int WIDTH     = 25,
  parameter int FRAC_BITS = 0
);
  logic                         start;
  logic [WIDTH-1:0]             A;
  logic [WIDTH-1:0]             B;
  logic                         ready;
  logic                         done;
  logic [WIDTH+FRAC_BITS-1:0]   result;
  logic [WIDTH-1:0]             remainder;
  logic                         dbz;

  modport master (
    output start, A, B,
    input  ready, done, result, remainder, dbz
  );

  modport slave (
    input  start, A, B,
    output ready, done, result, remainder, dbz
  );
endinterface

// File: rtl/div_step.sv
// One non-restoring division step: shift the next dividend bit into P,
// then subtract (mode=1) or add (mode=0) the divisor.
module div_step #(
  parameter int WIDTH = 25
) (
  input  logic [WIDTH:0]   p_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH:0]   p_out,
  output logic             q_bit
);

  logic [WIDTH:0] p_shift;

  always_comb begin
    p_shift = {p_in[WIDTH-1:0], bit_in};
    if (mode) begin
      p_out = p_shift - {1'b0, b};
    end else begin
      p_out = p_shift + {1'b0, b};
    end
    q_bit = ~p_out[WIDTH];
  end

endmodule

// File: rtl/div_seq.sv
// Sequential non-restoring divider: one quotient bit per clock, optional
// fraction bits, start/ready/done handshake and divide-by-zero reporting.
module div_seq
  import ktsnc_div_pkg::*;
#(
  parameter int WIDTH     = 25,
  parameter int FRAC_BITS = 0
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);

  localparam int N  = WIDTH + FRAC_BITS;
  localparam int CW = clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [N-1:0]     d_q, d_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div0_q, div0_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic [N-1:0]     result_q, result_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   step_p;
  logic             step_q;
  logic             step_sub;
  logic [WIDTH-1:0] rem_fix;

  assign step_sub = ~p_q[WIDTH];

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_in   (p_q),
    .bit_in (d_q[N-1]),
    .b      (b_q),
    .mode   (step_sub),
    .p_out  (step_p),
    .q_bit  (step_q)
  );

  // The corrected remainder lies in [0,B), so the low WIDTH bits of P+B suffice.
  assign rem_fix = p_q[WIDTH] ? (p_q[WIDTH-1:0] + b_q) : p_q[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    d_d      = d_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    div0_d   = div0_q;
    result_d = result_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.B != '0) begin
            b_d     = bus.B;
            p_d     = '0;
            d_d     = N'(bus.A) << FRAC_BITS;
            cnt_d   = CNT_LAST;
            div0_d  = 1'b0;
            state_d = ST_CALC;
          end else begin
            // Park A in P so FIX can publish it as the remainder.
            p_d     = {1'b0, bus.A};
            div0_d  = 1'b1;
            state_d = ST_FIX;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        p_d = step_p;
        d_d = {d_q[N-2:0], step_q};
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_FIX: begin
        if (div0_q) begin
          result_d = {N{DBZ_QUOTIENT}};
          rem_d    = p_q[WIDTH-1:0];
          dbz_d    = 1'b1;
        end else begin
          result_d = d_q;
          rem_d    = rem_fix;
          dbz_d    = 1'b0;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      p_q      <= '0;
      d_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      div0_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      result_q <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      d_q      <= d_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      div0_q   <= div0_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.remainder = rem_q;
  assign bus.dbz       = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq in integer (25/0) and mantissa (24/23) configurations.
module tb_div_seq;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  div_seq_if #(.WIDTH(25), .FRAC_BITS(0))  if_a ();
  div_seq_if #(.WIDTH(24), .FRAC_BITS(23)) if_b ();

  div_seq #(.WIDTH(25), .FRAC_BITS(0))  dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  div_seq #(.WIDTH(24), .FRAC_BITS(23)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one division on if_a; lat is the cycle in which done is seen.
  task automatic run_a(input logic [24:0] a, input logic [24:0] b, input bit noise,
                       output int lat, output logic rdy1);
    int w;
    int l;
    w = 0;
    @(negedge clk);
    while (if_a.ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if_a.start = 1'b1;
    if_a.A     = a;
    if_a.B     = b;
    @(posedge clk);
    #1;
    if_a.start = 1'b0;
    l    = 1;
    rdy1 = if_a.ready;
    while (if_a.done !== 1'b1 && l < 200) begin
      @(posedge clk);
      #1;
      l++;
      if (noise && (l == 5 || l == 12)) begin
        if_a.start = 1'b1;
        if_a.A     = 25'd77;
        if_a.B     = 25'd5;
      end else begin
        if_a.start = 1'b0;
      end
    end
    lat = l;
  endtask

  task automatic run_b(input logic [23:0] a, input logic [23:0] b, output int lat);
    int w;
    int l;
    w = 0;
    @(negedge clk);
    while (if_b.ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if_b.start = 1'b1;
    if_b.A     = a;
    if_b.B     = b;
    @(posedge clk);
    #1;
    if_b.start = 1'b0;
    l = 1;
    while (if_b.done !== 1'b1 && l < 200) begin
      @(posedge clk);
      #1;
      l++;
    end
    lat = l;
  endtask

  initial begin
    int          lat;
    int          done_seen;
    logic        rdy1;
    logic [24:0] ra;
    logic [24:0] rb;
    logic [23:0] ma;
    logic [23:0] mb;

    rst = 1'b1;
    if_a.start = 1'b0; if_a.A = '0; if_a.B = '0;
    if_b.start = 1'b0; if_b.A = '0; if_b.B = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready",  64'(if_a.ready),     64'd1);
    chk("rst_done",   64'(if_a.done),      64'd0);
    chk("rst_result", 64'(if_a.result),    64'd0);
    chk("rst_rem",    64'(if_a.remainder), 64'd0);
    chk("rst_dbz",    64'(if_a.dbz),       64'd0);
    chk("rst_ready_b", 64'(if_b.ready),    64'd1);

    run_a(25'd100, 25'd7, 1'b0, lat, rdy1);
    chk("d100_7_lat",    64'(lat),            64'd27);
    chk("d100_7_rdy1",   64'(rdy1),           64'd0);
    chk("d100_7_rdydn",  64'(if_a.ready),     64'd0);
    chk("d100_7_q",      64'(if_a.result),    64'd14);
    chk("d100_7_r",      64'(if_a.remainder), 64'd2);
    chk("d100_7_dbz",    64'(if_a.dbz),       64'd0);
    @(posedge clk);
    #1;
    chk("d100_7_rdy28",  64'(if_a.ready),     64'd1);
    chk("d100_7_done28", 64'(if_a.done),      64'd0);

    run_a(25'h1FFFFFF, 25'd1, 1'b0, lat, rdy1);
    chk("max_by1_q", 64'(if_a.result),    64'h1FFFFFF);
    chk("max_by1_r", 64'(if_a.remainder), 64'd0);
    run_a(25'd5, 25'd9, 1'b0, lat, rdy1);
    chk("a_lt_b_q", 64'(if_a.result),    64'd0);
    chk("a_lt_b_r", 64'(if_a.remainder), 64'd5);
    run_a(25'h1FFFFFF, 25'h1FFFFFF, 1'b0, lat, rdy1);
    chk("max_max_q", 64'(if_a.result),    64'd1);
    chk("max_max_r", 64'(if_a.remainder), 64'd0);
    run_a(25'd0, 25'd5, 1'b0, lat, rdy1);
    chk("zero_q", 64'(if_a.result),    64'd0);
    chk("zero_r", 64'(if_a.remainder), 64'd0);

    run_a(25'd1234, 25'd0, 1'b0, lat, rdy1);
    chk("dbz_lat", 64'(lat),              64'd2);
    chk("dbz_q",   64'(if_a.result),      64'h1FFFFFF);
    chk("dbz_r",   64'(if_a.remainder),   64'd1234);
    chk("dbz_flag", 64'(if_a.dbz),        64'd1);
    run_a(25'd6, 25'd3, 1'b0, lat, rdy1);
    chk("after_dbz_flag", 64'(if_a.dbz),    64'd0);
    chk("after_dbz_q",    64'(if_a.result), 64'd2);

    // Stray starts while busy must be ignored.
    run_a(25'd1000, 25'd3, 1'b1, lat, rdy1);
    chk("noise_lat", 64'(lat),              64'd27);
    chk("noise_q",   64'(if_a.result),      64'd333);
    chk("noise_r",   64'(if_a.remainder),   64'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("hold_q",    64'(if_a.result),    64'd333);
      chk("hold_r",    64'(if_a.remainder), 64'd1);
      chk("hold_dbz",  64'(if_a.dbz),       64'd0);
      chk("hold_done", 64'(if_a.done),      64'd0);
    end

    // Reset during cycle 10 of an operation aborts it without a done.
    @(negedge clk);
    if_a.start = 1'b1;
    if_a.A     = 25'd50;
    if_a.B     = 25'd3;
    @(posedge clk);
    #1;
    if_a.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_ready",  64'(if_a.ready),     64'd1);
    chk("abort_result", 64'(if_a.result),    64'd0);
    chk("abort_rem",    64'(if_a.remainder), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (if_a.done === 1'b1) done_seen++;
    end
    chk("abort_no_done", 64'(done_seen), 64'd0);
    run_a(25'd100, 25'd7, 1'b0, lat, rdy1);
    chk("post_abort_lat", 64'(lat),              64'd27);
    chk("post_abort_q",   64'(if_a.result),      64'd14);
    chk("post_abort_r",   64'(if_a.remainder),   64'd2);

    run_b(24'h800000, 24'h800000, lat);
    chk("m_one_lat", 64'(lat),              64'd49);
    chk("m_one_q",   64'(if_b.result),      64'h800000);
    chk("m_one_r",   64'(if_b.remainder),   64'd0);
    run_b(24'hC00000, 24'h800000, lat);
    chk("m_1p5_q", 64'(if_b.result),    64'hC00000);
    chk("m_1p5_r", 64'(if_b.remainder), 64'd0);
    run_b(24'h800000, 24'hC00000, lat);
    chk("m_2_3_q", 64'(if_b.result),    64'h555555);
    chk("m_2_3_r", 64'(if_b.remainder), 64'h400000);
    run_b(24'd5, 24'd1, lat);
    chk("m_by1_q", 64'(if_b.result),    64'h2800000);
    chk("m_by1_r", 64'(if_b.remainder), 64'd0);

    for (int i = 0; i < 60; i++) begin
      ra = 25'($urandom);
      rb = 25'($urandom) >> $urandom_range(0, 24);
      if (rb == 25'd0) rb = 25'd1;
      run_a(ra, rb, 1'b0, lat, rdy1);
      chk("rand_a_q", 64'(if_a.result),    64'(ra) / 64'(rb));
      chk("rand_a_r", 64'(if_a.remainder), 64'(ra) % 64'(rb));
    end
    for (int i = 0; i < 60; i++) begin
      ma = 24'($urandom);
      mb = 24'($urandom) >> $urandom_range(0, 23);
      if (mb == 24'd0) mb = 24'd1;
      run_b(ma, mb, lat);
      chk("rand_b_q", 64'(if_b.result),    (64'(ma) << 23) / 64'(mb));
      chk("rand_b_r", 64'(if_b.remainder), (64'(ma) << 23) % 64'(mb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
